// File: rtl/seven_seg_scan.sv
// seven_seg_scan -- time-multiplexed digit scanner for a common-segment
// multi-digit 7-segment display.
//
// Holds a hex value and shows one nibble at a time to an external
// nibble-to-segment decoder, with a matching one-hot digit enable. Each digit
// slot begins with a blanking interval (all enables low) so the decoder can
// settle on the new nibble before its digit lights up. New values are
// committed only at the start of slot 0, so a frame never shows a mix of old
// and new digits.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   When defined, digits above the most significant nonzero nibble of the
//   committed value stay dark. Digit 0 is always shown. Timing and nibble_out
//   are not affected.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   value_in     hex value, nibble d drives digit d (digit 0 = [3:0])
//   load         one-cycle strobe, captures value_in for the next frame
//   nibble_out   nibble for the digit currently being scanned
//   digit_sel    one-hot digit enable, all-zero while blanking
//   frame_start  one-cycle pulse after the edge that begins slot 0
//
// Timing: the counters hold the (slot, phase) that the next edge presents.
// Every output register is loaded from the current counter values, so after
// the n-th edge out of reset the outputs reflect slot floor((n-1)/DIV) mod
// NUM_DIGITS, phase (n-1) mod DIV.

module seven_seg_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV          = 12000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  output logic [3:0]              nibble_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_start
);

  localparam int SW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(DIV - 1);
  localparam logic [SW-1:0] BLANK_END  = SW'(BLANK_CYCLES);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);

  // scan position presented at the next edge
  logic [SW-1:0] slot_cnt;
  logic [DW-1:0] digit_idx;

  // value storage
  logic [VW-1:0] pending;
  logic          pending_valid;
  logic [VW-1:0] display;

  // combinational helpers
  logic          frame_edge;   // the coming edge begins slot 0
  logic          slot_wrap;    // the coming edge is the last phase of a slot
  logic [VW-1:0] display_nxt;
  logic [3:0]    nib_nxt;
  logic          in_window;
  logic          digit_on;
  logic [NUM_DIGITS-1:0] sel_nxt;

  assign frame_edge = (slot_cnt == '0) && (digit_idx == '0);
  assign slot_wrap  = (slot_cnt == SLOT_LAST);
  assign in_window  = (slot_cnt >= BLANK_END);

  // Commit happens only at the frame edge. A load on that very edge wins over
  // anything pending so it shows without a one-frame delay.
  always_comb begin
    display_nxt = display;
    if (frame_edge) begin
      if (load)               display_nxt = value_in;
      else if (pending_valid) display_nxt = pending;
    end
  end

  // Nibble for the slot being presented. Taken from display_nxt so a value
  // committed on this edge is already visible in slot 0.
  always_comb begin
    nib_nxt = 4'h0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (digit_idx == DW'(d)) nib_nxt = display_nxt[4*d +: 4];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Index of the highest nonzero nibble of the committed value; 0 when the
  // value is zero so digit 0 still shows "0".
  logic [DW-1:0] msd_idx;
  logic [DW-1:0] msd_nxt;

  always_comb begin
    msd_nxt = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (display_nxt[4*d +: 4] != 4'h0) msd_nxt = DW'(d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)             msd_idx <= '0;
    else if (frame_edge) msd_idx <= msd_nxt;
  end

  // Slot 0 is always blanked at the frame edge, so the registered msd_idx is
  // already current by the time any enable window opens.
  assign digit_on = (digit_idx <= msd_idx);
`else
  assign digit_on = 1'b1;
`endif

  assign sel_nxt = (in_window && digit_on) ? (ONE_HOT0 << digit_idx)
                                           : '0;

  // scan counters
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else begin
      slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
      if (slot_wrap) digit_idx <= (digit_idx == DIGIT_LAST) ? '0 : digit_idx + 1'b1;
    end
  end

  // pending / display registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pending       <= '0;
      pending_valid <= 1'b0;
      display       <= '0;
    end else begin
      display <= display_nxt;
      if (frame_edge) begin
        pending_valid <= 1'b0;
      end else if (load) begin
        pending       <= value_in;
        pending_valid <= 1'b1;
      end
    end
  end

  // Output registers. nibble_out only moves at phase 0, which is always
  // blanked, so the decoder output is stable before the enable rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      nibble_out  <= 4'h0;
      digit_sel   <= '0;
      frame_start <= 1'b0;
    end else begin
      if (slot_cnt == '0) nibble_out <= nib_nxt;
      digit_sel   <= sel_nxt;
      frame_start <= frame_edge;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan (NUM_DIGITS=4, DIV=8, BLANK_CYCLES=2).
// A reference model counts edges since reset release and derives slot/phase
// arithmetically; a compare process checks every output on every falling edge.
// Directed literal checks pin the model to hand-computed timeline values.
module tb_seven_seg_scan;
  localparam int ND    = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   value_in;
  logic          load;
  logic [3:0]    nibble_out;
  logic [ND-1:0] digit_sel;
  logic          frame_start;

  int n_chk  = 0;
  int n_fail = 0;

  seven_seg_scan #(.NUM_DIGITS(ND), .DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst(rst), .value_in(value_in), .load(load),
    .nibble_out(nibble_out), .digit_sel(digit_sel), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // reference model
  int          n = 0;         // edges since reset release
  int          ms, mp;        // slot and phase of the latest edge
  logic [15:0] m_disp, m_pend;
  bit          m_pv;
  int          m_msd;
  logic [3:0]  e_nib;
  logic [3:0]  e_sel;
  logic        e_fs;
  bit          mvalid = 1'b0;

  always @(posedge clk) begin
    mvalid = 1'b1;
    if (rst) begin
      n = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0; m_msd = 0;
      e_nib = '0; e_sel = '0; e_fs = 1'b0;
    end else begin
      n++;
      ms = ((n - 1) / DIV) % ND;
      mp = (n - 1) % DIV;
      if (ms == 0 && mp == 0) begin
        if (load)      m_disp = value_in;
        else if (m_pv) m_disp = m_pend;
        m_pv  = 1'b0;
        m_msd = 0;
        for (int d = 0; d < ND; d++)
          if (((m_disp >> (4 * d)) & 16'hF) != 0) m_msd = d;
      end else if (load) begin
        m_pend = value_in;
        m_pv   = 1'b1;
      end
      e_nib = 4'((m_disp >> (4 * ms)) & 16'hF);
      e_fs  = (ms == 0 && mp == 0);
      e_sel = (mp < BLANK || (LZB && ms > m_msd)) ? 4'b0000 : 4'(1 << ms);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s edge %0d: got %0h expected %0h", nm, n, act, exp);
    end
  endtask

  // compare process
  always @(negedge clk) begin
    if (mvalid) begin
      chk("nibble_out",  32'(nibble_out),  32'(e_nib));
      chk("digit_sel",   32'(digit_sel),   32'(e_sel));
      chk("frame_start", 32'(frame_start), 32'(e_fs));
    end
  end

  task automatic cyc(input logic l, input logic [15:0] v);
    load = l; value_in = v;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  logic        l;
  logic [15:0] v;
  int          rst_hold;

  initial begin
    rst = 1'b1; load = 1'b0; value_in = '0;
    cyc(0, 16'h0); cyc(0, 16'h0);
    rst = 1'b0;

    // directed timeline; e is the edge number since release
    for (int e = 1; e <= 147; e++) begin
      l = 1'b0; v = 16'($urandom);
      if (e == 5)   begin l = 1'b1; v = 16'hA3C5; end
      if (e == 74)  begin l = 1'b1; v = 16'h1111; end
      if (e == 84)  begin l = 1'b1; v = 16'h2222; end
      if (e == 129) begin l = 1'b1; v = 16'h7777; end
      cyc(l, v);
      case (e)
        1:   begin chk("lit fs e1", 32'(frame_start), 1); chk("lit sel e1", 32'(digit_sel), 0); end
        2:   begin chk("lit sel e2", 32'(digit_sel), 0); chk("lit fs e2", 32'(frame_start), 0); end
        3:   chk("lit sel e3", 32'(digit_sel), 1);
        8:   chk("lit sel e8", 32'(digit_sel), 1);
        9:   chk("lit sel e9", 32'(digit_sel), 0);
        11:  chk("lit sel e11", 32'(digit_sel), LZB ? 0 : 2);
        27:  chk("lit sel e27", 32'(digit_sel), LZB ? 0 : 8);
        30:  chk("lit nib e30", 32'(nibble_out), 0);
        33:  begin chk("lit fs e33", 32'(frame_start), 1); chk("lit nib e33", 32'(nibble_out), 5); end
        43:  chk("lit nib e43", 32'(nibble_out), 12);
        51:  chk("lit nib e51", 32'(nibble_out), 3);
        59:  begin chk("lit nib e59", 32'(nibble_out), 10); chk("lit sel e59", 32'(digit_sel), 8); end
        65:  chk("lit fs e65", 32'(frame_start), 1);
        67:  chk("lit nib e67", 32'(nibble_out), 5);
        97:  begin chk("lit fs e97", 32'(frame_start), 1); chk("lit nib e97", 32'(nibble_out), 2); end
        107: chk("lit nib e107", 32'(nibble_out), 2);
        123: begin chk("lit nib e123", 32'(nibble_out), 2); chk("lit sel e123", 32'(digit_sel), 8); end
        129: begin chk("lit nib e129", 32'(nibble_out), 7); chk("lit fs e129", 32'(frame_start), 1); end
        139: begin chk("lit nib e139", 32'(nibble_out), 7); chk("lit sel e139", 32'(digit_sel), 2); end
        default: ;
      endcase
    end

    // reset mid-window of slot 2 (edge 147 was slot 2, phase 2)
    rst = 1'b1;
    cyc(0, 16'h0);
    chk("lit rst sel", 32'(digit_sel), 0);
    chk("lit rst nib", 32'(nibble_out), 0);
    chk("lit rst fs",  32'(frame_start), 0);
    cyc(0, 16'h0);
    rst = 1'b0;
    cyc(0, 16'($urandom));
    chk("lit post-rst fs",  32'(frame_start), 1);
    chk("lit post-rst nib", 32'(nibble_out), 0);
    cyc(0, 16'($urandom));
    cyc(0, 16'($urandom));
    chk("lit post-rst sel", 32'(digit_sel), 1);

    // randomized phase
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        rst_hold = $urandom_range(1, 3);
        for (int k = 0; k < rst_hold; k++) cyc(1'($urandom_range(0, 1)), 16'($urandom));
        rst = 1'b0;
      end
      l = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0: v = 16'($urandom) & 16'h000F;
        1: v = 16'($urandom) & 16'h00FF;
        2: v = 16'h0000;
        default: v = 16'($urandom);
      endcase
      cyc(l, v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Time-multiplexed digit scanner for a multi-digit common-segment 7-segment display.
- Holds a hex value and presents one nibble at a time to the downstream nibble-to-segment decoder.
- Drives the matching one-hot digit enable.
- Inserts a blanking interval at every digit switch to suppress ghosting.
- Updates the displayed value only on frame boundaries to avoid tearing.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- DIV, 12000, clock cycles per digit slot (1 kHz slot at 12 MHz); must be > BLANK_CYCLES.
- BLANK_CYCLES, 16, cycles at the start of each slot with all digits disabled (>= 1).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high. One clock; reset is synchronous and active-high.
- value_in  input  4*NUM_DIGITS  hex value to display; nibble d drives digit d, where digit 0 = value_in[3:0] = least significant.
- load  input  1  one-cycle strobe that captures value_in into the pending register.
- nibble_out  output  4  nibble for the currently scanned digit, fed to the segment decoder.
- digit_sel  output  NUM_DIGITS  one-hot digit enable, active-high; all-zero while blanking.
- frame_start  output  1  one-cycle pulse at the start of slot 0.

Behaviour:
- All outputs are registered.
- Reset (rst high at a rising edge) clears all registers:
  - slot_cnt=0, digit_idx=0, pending=0, pending_valid=0, display=0.
  - nibble_out=0, digit_sel=0, frame_start=0.
- Reset mid-frame aborts the scan immediately; the next slot after release is digit 0.
- Timeline: edge 1 is the first rising edge with rst low. At edge n (n >= 1):
  - slot s = floor((n-1)/DIV) mod NUM_DIGITS.
  - phase p = (n-1) mod DIV.
  - Outputs after edge n reflect (s, p).
- Slot counter: phase runs 0..DIV-1 and wraps to 0. On wrap, digit_idx increments, wrapping from NUM_DIGITS-1 to 0.
- Blanking: digit_sel = 0 for p < BLANK_CYCLES; digit_sel = (1 << s) for BLANK_CYCLES <= p <= DIV-1.
- nibble_out = display[4s+3:4s]. It changes only at p=0, while blanked, so the decoder settles before enable.
- Load capture: load high at an edge sets pending = value_in and pending_valid = 1. A later load before commit overwrites pending (last load wins).
- Commit at the edge that begins slot 0 (s=0, p=0):
  - If load is high at that same edge, display = value_in directly, and pending_valid clears.
  - Else if pending_valid, display = pending, and pending_valid clears.
  - Else display is unchanged.
- A load at any other edge becomes visible on the next slot 0.
- frame_start is high for exactly the cycle following each edge beginning slot 0, including the first slot 0 after reset.
- Widths: slot_cnt is clog2(DIV) bits; digit_idx is clog2(NUM_DIGITS) bits. NUM_DIGITS need not be a power of two; wrap is explicit.
- Outside blanking, at most one digit_sel bit is ever high.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- When defined:
  - At commit, compute the index of the most significant nonzero nibble of the new display value (0 if the value is all zero).
  - Slots above that index keep digit_sel = 0 for the whole slot; timing and nibble_out are unchanged.
  - Digit 0 is always shown, so the value 0 displays as a single "0".
- When undefined: all NUM_DIGITS digits are always enabled in their display window, leading zeros included.

Test Plan (NUM_DIGITS=4, DIV=8, BLANK_CYCLES=2 unless stated):
1. Reset release, no load -> nibble_out=0 throughout; frame_start high after edges 1, 33, 65; digit_sel=0001 after edges 3..8, 0010 after 11..16, 0100 after 19..24, 1000 after 27..32; digit_sel=0000 after edges 1, 2, 9, 10.
2. load with value_in=16'hA3C5 at edge 5 -> display unchanged until edge 33; then nibble_out = 5, C, 3, A in slots 0..3; digit_sel stays one-hot during windows.
3. load 16'h1111 at edge 10, then 16'h2222 at edge 20 -> frame from edge 33 shows 2,2,2,2; no frame shows 1.
4. load 16'h7777 exactly at edge 33 (commit edge) -> slot 0 after edge 33 shows nibble_out=7 with no one-frame delay.
5. rst high at edge 20 (slot 2, mid-window), released at edge 22 -> digit_sel=0, nibble_out=0, display=0 after edge 20; scan restarts at digit 0 with frame_start after the next edge.
6. With LEADING_ZERO_BLANK_EN, load 16'h00F0 -> digit_sel pulses 0001 and 0010 only; slots 2 and 3 stay 0000. With 16'h0000, only 0001 pulses and nibble_out=0.
